// File: rtl/a2d_rr_sched.sv
`timescale 1ns/1ps
// a2d_rr_sched: round-robin sequencer driving a shared SPI master through the
// two-frame A2D conversion (result returns one frame late) for lft/rght/batt.
module a2d_rr_sched #(
    parameter logic [2:0] CH_LFT  = 3'd0,
    parameter logic [2:0] CH_RGHT = 3'd4,
    parameter logic [2:0] CH_BATT = 3'd5,
    parameter int         GAP_CYC = 4,
    parameter int         TIMEOUT = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        upd,
    output logic [1:0]  upd_ch,
    output logic        busy,
    output logic        tmo_err
);

    typedef enum logic [2:0] {
        IDLE, SEND1, WAIT1, GAP, SEND2, WAIT2, LATCH
    } state_t;

    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  rr_q;
    logic [7:0]  gap_cnt_q;
    logic [15:0] tmo_cnt_q;
    logic        wrt_q;
    logic        upd_q;
    logic        busy_q;
    logic        tmo_err_q;
    logic [1:0]  upd_ch_q;
    logic [15:0] cmd_q;
    logic [11:0] lft_q;
    logic [11:0] rght_q;
    logic [11:0] batt_q;
    logic [2:0]  ch_d;
    logic [15:0] cmd_d;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        ch_d = CH_LFT;
        case (rr_q)
            2'd1:    ch_d = CH_RGHT;
            2'd2:    ch_d = CH_BATT;
            default: ch_d = CH_LFT;
        endcase
        cmd_d = {2'b00, ch_d, 11'h000};
    end

    // NOTE: sequential state uses non-blocking assignments only; the result
    // registers are reset too because they are visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 2'd0;
            gap_cnt_q <= 8'd0;
            tmo_cnt_q <= 16'd0;
            wrt_q     <= 1'b0;
            upd_q     <= 1'b0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            upd_ch_q  <= 2'd0;
            cmd_q     <= 16'h0000;
            lft_q     <= 12'h000;
            rght_q    <= 12'h000;
            batt_q    <= 12'h000;
        end else begin
            wrt_q <= 1'b0;
            upd_q <= 1'b0;
            case (state_q)
                IDLE: if (nxt) begin
                    state_q <= SEND1;
                    busy_q  <= 1'b1;
                    cmd_q   <= cmd_d;
                end
                SEND1: begin
                    wrt_q     <= 1'b1;
                    tmo_cnt_q <= 16'd0;
                    state_q   <= WAIT1;
                end
                WAIT1: begin
                    // Frame 1 returns the previous conversion; its data is dropped.
                    if (done) begin
                        gap_cnt_q <= 8'd0;
                        state_q   <= GAP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_q <= SEND2;
                    else                        gap_cnt_q <= gap_cnt_q + 8'd1;
                end
                SEND2: begin
                    wrt_q     <= 1'b1;
                    tmo_cnt_q <= 16'd0;
                    state_q   <= WAIT2;
                end
                WAIT2: begin
                    if (done) begin
                        case (rr_q)
                            2'd1:    rght_q <= rd_data[11:0];
                            2'd2:    batt_q <= rd_data[11:0];
                            default: lft_q  <= rd_data[11:0];
                        endcase
                        upd_q     <= 1'b1;
                        upd_ch_q  <= rr_q;
                        tmo_err_q <= 1'b0;
                        rr_q      <= (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
                        state_q   <= LATCH;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                LATCH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign lft_ld  = lft_q;
    assign rght_ld = rght_q;
    assign batt    = batt_q;
    assign upd     = upd_q;
    assign upd_ch  = upd_ch_q;
    assign busy    = busy_q;
    assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
`timescale 1ns/1ps
// Directed bench for a2d_rr_sched with a small SPI/A2D responder model.
module tb_a2d_rr_sched;

    localparam int GAP_CYC = 4;
    localparam int TIMEOUT = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        wrt;
    logic [15:0] cmd;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        upd;
    logic [1:0]  upd_ch;
    logic        busy;
    logic        tmo_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Responder controls (written by the stimulus process only)
    logic        model_clr = 1'b1;
    logic        drop2 = 1'b0;
    logic [15:0] resp2 = 16'h0000;

    // Responder observations (written by the responder process only)
    int          wrt_cnt = 0;
    int          upd_total = 0;
    int          dly = 0;
    int          done1_cyc = 0;
    int          done2_cyc = 0;
    int          wrt_cyc_q[$];
    int          upd_cyc_q[$];
    logic [15:0] cmd_log[$];

    a2d_rr_sched #(
        .CH_LFT(3'd0), .CH_RGHT(3'd4), .CH_BATT(3'd5),
        .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd),
        .done(done), .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .batt(batt), .upd(upd), .upd_ch(upd_ch), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // A2D responder: done three clocks after each wrt; frame 1 returns junk,
    // frame 2 returns resp2 (or nothing when drop2 is set).
    initial forever begin
        @(negedge clk);
        if (model_clr) begin
            done = 1'b0; rd_data = 16'h0000; dly = 0; wrt_cnt = 0; upd_total = 0;
            wrt_cyc_q.delete(); upd_cyc_q.delete(); cmd_log.delete();
        end else begin
            done = 1'b0;
            if (dly > 0) begin
                dly = dly - 1;
                if (dly == 0) begin
                    if (wrt_cnt % 2 == 0) begin
                        if (!drop2) begin
                            done = 1'b1; rd_data = resp2; done2_cyc = cyc;
                        end
                    end else begin
                        done = 1'b1; rd_data = 16'hFFFF; done1_cyc = cyc;
                    end
                end
            end
            if (wrt === 1'b1) begin
                wrt_cnt = wrt_cnt + 1;
                wrt_cyc_q.push_back(cyc);
                cmd_log.push_back(cmd);
                dly = 3;
            end
            if (upd === 1'b1) begin
                upd_total = upd_total + 1;
                upd_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; model_clr = 1'b1; nxt = 1'b0; drop2 = 1'b0;
        repeat (3) step();
        rst = 1'b0; model_clr = 1'b0;
        step();
    endtask

    // One nxt pulse, then wait (bounded) for upd; reports busy one clock after nxt.
    task automatic convert(input logic [15:0] resp, output bit ok,
                           output int nxt_cyc, output logic busy_after);
        int n0;
        n0 = upd_total;
        resp2 = resp;
        nxt = 1'b1; nxt_cyc = cyc;
        step();
        busy_after = busy;
        nxt = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (upd_total != n0) ok = 1'b1;
        end
        step(); step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({wrt, upd, busy, tmo_err} !== 4'b0000) begin failures++;
            $display("FAIL reset_flags: got %b exp 0000", {wrt, upd, busy, tmo_err}); end
        checks++; if (cmd !== 16'h0000) begin failures++;
            $display("FAIL reset_cmd: got %h exp 0000", cmd); end
        checks++; if ({lft_ld, rght_ld, batt, upd_ch} !== 38'h0) begin failures++;
            $display("FAIL reset_regs: got %h %h %h %0d exp all 0", lft_ld, rght_ld, batt, upd_ch); end
    endtask

    task automatic test_single();
        bit ok; int nc; logic b; int idle;
        do_reset();
        convert(16'h0ABC, ok, nc, b);
        checks++; if (!ok) begin failures++; $display("FAIL single_upd: got no upd exp upd"); end
        checks++; if (b !== 1'b1) begin failures++; $display("FAIL single_busy_rise: got %b exp 1", b); end
        checks++; if (wrt_cnt != 2) begin failures++; $display("FAIL single_wrt_cnt: got %0d exp 2", wrt_cnt); end
        if (wrt_cnt == 2) begin
            checks++; if (cmd_log[0] !== 16'h0000 || cmd_log[1] !== 16'h0000) begin failures++;
                $display("FAIL single_cmd: got %h %h exp 0000 0000", cmd_log[0], cmd_log[1]); end
            checks++; if (wrt_cyc_q[0] - nc != 2) begin failures++;
                $display("FAIL single_nxt_to_wrt: got %0d exp 2", wrt_cyc_q[0] - nc); end
            idle = wrt_cyc_q[1] - done1_cyc - 1;
            checks++; if (idle < GAP_CYC || idle > GAP_CYC + 1) begin failures++;
                $display("FAIL single_gap: got %0d exp %0d..%0d", idle, GAP_CYC, GAP_CYC + 1); end
        end
        checks++; if (lft_ld !== 12'hABC) begin failures++; $display("FAIL single_lft: got %h exp abc", lft_ld); end
        checks++; if (upd_ch !== 2'd0) begin failures++; $display("FAIL single_upd_ch: got %0d exp 0", upd_ch); end
        if (upd_total == 1) begin
            checks++; if (upd_cyc_q[0] - done2_cyc != 1) begin failures++;
                $display("FAIL single_done_to_upd: got %0d exp 1", upd_cyc_q[0] - done2_cyc); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b exp 0", busy); end
    endtask

    task automatic test_rotation();
        bit ok; int nc; logic b;
        logic [15:0] exp_cmd [7];
        exp_cmd = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800, 16'h0000};
        do_reset();
        convert(16'h0111, ok, nc, b);
        convert(16'h0222, ok, nc, b);
        convert(16'h0333, ok, nc, b);
        checks++; if (upd_ch !== 2'd2) begin failures++; $display("FAIL rot_upd_ch: got %0d exp 2", upd_ch); end
        convert(16'h0444, ok, nc, b);
        checks++; if (cmd_log.size() != 8) begin failures++;
            $display("FAIL rot_wrt_cnt: got %0d exp 8", cmd_log.size()); end
        else for (int i = 0; i < 7; i++) begin
            checks++; if (cmd_log[i] !== exp_cmd[i]) begin failures++;
                $display("FAIL rot_cmd%0d: got %h exp %h", i, cmd_log[i], exp_cmd[i]); end
        end
        checks++; if (lft_ld !== 12'h444 || rght_ld !== 12'h222 || batt !== 12'h333) begin failures++;
            $display("FAIL rot_regs: got %h %h %h exp 444 222 333", lft_ld, rght_ld, batt); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        do_reset();
        resp2 = 16'h0456;
        nxt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            if (upd_total == 3) seen = 1'b1;
        end
        nxt = 1'b0;
        repeat (20) step();
        checks++; if (!seen) begin failures++; $display("FAIL b2b_timeout: got %0d upd exp 3", upd_total); end
        checks++; if (wrt_cnt != 6) begin failures++; $display("FAIL b2b_wrt_cnt: got %0d exp 6", wrt_cnt); end
        checks++; if (upd_total != 3) begin failures++; $display("FAIL b2b_upd_cnt: got %0d exp 3", upd_total); end
        if (wrt_cnt >= 3 && upd_total >= 1) begin
            checks++; if (wrt_cyc_q[2] - upd_cyc_q[0] != 3) begin failures++;
                $display("FAIL b2b_restart: got %0d exp 3", wrt_cyc_q[2] - upd_cyc_q[0]); end
        end
        if (wrt_cnt == 6) begin
            checks++; if (cmd_log[2] !== 16'h2000 || cmd_log[4] !== 16'h2800) begin failures++;
                $display("FAIL b2b_cmd: got %h %h exp 2000 2800", cmd_log[2], cmd_log[4]); end
        end
        checks++; if (lft_ld !== 12'h456 || rght_ld !== 12'h456 || batt !== 12'h456 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_regs: got %h %h %h busy=%b exp 456 456 456 busy=0",
                                 lft_ld, rght_ld, batt, busy); end
    endtask

    task automatic test_timeout();
        bit ok; int nc; logic b; bit seen; int tmo_cyc;
        do_reset();
        convert(16'h05A5, ok, nc, b);
        drop2 = 1'b1;
        nxt = 1'b1; step(); nxt = 1'b0;
        seen = 1'b0; tmo_cyc = 0;
        for (int i = 0; i < TIMEOUT + 100 && !seen; i++) begin
            step();
            if (tmo_err === 1'b1) begin seen = 1'b1; tmo_cyc = cyc; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL tmo_flag: got 0 exp 1"); end
        if (seen && wrt_cnt == 4) begin
            checks++; if (tmo_cyc - wrt_cyc_q[3] != TIMEOUT) begin failures++;
                $display("FAIL tmo_latency: got %0d exp %0d", tmo_cyc - wrt_cyc_q[3], TIMEOUT); end
        end
        step();
        checks++; if (upd_total != 1 || busy !== 1'b0) begin failures++;
            $display("FAIL tmo_no_upd: got upd=%0d busy=%b exp upd=1 busy=0", upd_total, busy); end
        checks++; if (lft_ld !== 12'h5A5 || rght_ld !== 12'h000) begin failures++;
            $display("FAIL tmo_regs: got %h %h exp 5a5 000", lft_ld, rght_ld); end
        drop2 = 1'b0;
        convert(16'h0777, ok, nc, b);
        checks++; if (cmd_log.size() != 6) begin failures++;
            $display("FAIL tmo_retry_cnt: got %0d exp 6", cmd_log.size()); end
        else begin
            checks++; if (cmd_log[3] !== 16'h2000 || cmd_log[4] !== 16'h2000) begin failures++;
                $display("FAIL tmo_retry_cmd: got %h %h exp 2000 2000", cmd_log[3], cmd_log[4]); end
        end
        checks++; if (rght_ld !== 12'h777 || tmo_err !== 1'b0 || upd_ch !== 2'd1) begin failures++;
            $display("FAIL tmo_recover: got %h tmo=%b ch=%0d exp 777 tmo=0 ch=1", rght_ld, tmo_err, upd_ch); end
    endtask

    task automatic test_mask();
        bit ok; int nc; logic b;
        do_reset();
        convert(16'hF123, ok, nc, b);
        checks++; if (lft_ld !== 12'h123) begin failures++; $display("FAIL mask: got %h exp 123", lft_ld); end
    endtask

    task automatic test_reset_mid();
        bit ok; int nc; logic b; bit seen;
        do_reset();
        convert(16'h0321, ok, nc, b);
        nxt = 1'b1; step(); nxt = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (wrt === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || cmd !== 16'h2000) begin failures++;
            $display("FAIL rstmid_setup: got wrt_seen=%b cmd=%h exp 1 2000", seen, cmd); end
        rst = 1'b1; model_clr = 1'b1;
        #1;
        checks++; if ({wrt, busy, upd} !== 3'b000 || cmd !== 16'h0000 || lft_ld !== 12'h000) begin
            failures++; $display("FAIL rstmid_async: got wrt=%b busy=%b upd=%b cmd=%h lft=%h exp all 0",
                                 wrt, busy, upd, cmd, lft_ld); end
        repeat (3) step();
        rst = 1'b0; model_clr = 1'b0;
        step();
        convert(16'h0654, ok, nc, b);
        checks++; if (cmd_log.size() < 1 || cmd_log[0] !== 16'h0000 || lft_ld !== 12'h654) begin
            failures++; $display("FAIL rstmid_restart: got n=%0d lft=%h exp cmd0=0000 lft=654",
                                 cmd_log.size(), lft_ld); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_back_to_back();
        test_timeout();
        test_mask();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
